// File: rtl/mlu_seq_pkg.sv
// Shared types for the bit-serial MLU: opcode encoding, FSM states and opcode
// classification helpers.
package mlu_seq_pkg;

  typedef enum logic [2:0] {
    MLU_ADD  = 3'd0,
    MLU_SUB  = 3'd1,
    MLU_AND  = 3'd2,
    MLU_OR   = 3'd3,
    MLU_XOR  = 3'd4,
    MLU_NOT  = 3'd5,
    MLU_NOP0 = 3'd6,
    MLU_NOP1 = 3'd7
  } mlu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mlu_seq_state_t;

  // Only the add/subtract ops produce carry and signed-overflow flags.
  function automatic logic is_arith(input mlu_op_t op);
    return (op == MLU_ADD) || (op == MLU_SUB);
  endfunction

endpackage

// File: rtl/mlu_seq_if.sv
// Request/result handshake bundle between the operand source and the MLU.
// master = requester/consumer, slave = the MLU itself.
interface mlu_seq_if #(
  parameter int WIDTH = 32
);
  import mlu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  mlu_op_t          op;
  logic             c_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             c_out;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, a, b, op, c_in, out_ready,
    input  in_ready, out_valid, out, c_out, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, op, c_in, out_ready,
    output in_ready, out_valid, out, c_out, zero, neg, ovf
  );

endinterface

// File: rtl/mlu_slice_fn.sv
// One SLICE_W-bit slice of the MLU function; purely combinational.
module mlu_slice_fn
  import mlu_seq_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  mlu_op_t            op,
  input  logic               c_in,
  output logic [SLICE_W-1:0] r,
  output logic               c_out,
  output logic               zero
);

  logic [SLICE_W:0]   sum;
  logic [SLICE_W-1:0] b_n;

  always_comb begin
    sum   = '0;
    r     = '0;
    c_out = 1'b0;
    b_n   = ~b;
    case (op)
      MLU_ADD: begin
        sum   = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, c_in};
        r     = sum[SLICE_W-1:0];
        c_out = sum[SLICE_W];
      end
      MLU_SUB: begin
        sum   = {1'b0, a} + {1'b0, b_n} + {{SLICE_W{1'b0}}, c_in};
        r     = sum[SLICE_W-1:0];
        c_out = sum[SLICE_W];
      end
      MLU_AND: r = a & b;
      MLU_OR:  r = a | b;
      MLU_XOR: r = a ^ b;
      MLU_NOT: r = ~a;
      default: r = '0;
    endcase
    zero = (r == '0);
  end

endmodule

// File: rtl/mlu_seq.sv
// Bit-serial MLU: one SLICE_W slice per clock, LSB slice first, with the carry
// and zero state rippled through registers between slices.
module mlu_seq
  import mlu_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  mlu_seq_if.slave   bus
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  mlu_seq_state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, out_q;
  mlu_op_t          op_q;
  logic [CNT_W-1:0] cnt;
  logic             carry_q, zacc_q;
  logic             c_out_q, zero_q, neg_q, ovf_q;

  logic [SLICE_W-1:0] s_r;
  logic               s_c, s_z;
  logic               last, a_msb, b_msb, s_ovf;

  mlu_slice_fn #(.SLICE_W(SLICE_W)) u_slice (
    .a     (a_sh[SLICE_W-1:0]),
    .b     (b_sh[SLICE_W-1:0]),
    .op    (op_q),
    .c_in  (carry_q),
    .r     (s_r),
    .c_out (s_c),
    .zero  (s_z)
  );

  assign last  = (cnt == CNT_W'(N - 1));
  assign a_msb = a_sh[SLICE_W-1];
  // Subtraction overflows like an add of the inverted subtrahend.
  assign b_msb = (op_q == MLU_SUB) ? ~b_sh[SLICE_W-1] : b_sh[SLICE_W-1];
  assign s_ovf = is_arith(op_q) && (a_msb == b_msb) && (s_r[SLICE_W-1] != a_msb);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = BUSY;
      BUSY:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      out_q   <= '0;
      op_q    <= MLU_NOP0;
      cnt     <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      c_out_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_sh    <= bus.a;
          b_sh    <= bus.b;
          op_q    <= bus.op;
          carry_q <= bus.c_in;
          cnt     <= '0;
          zacc_q  <= 1'b1;
        end
        BUSY: begin
          out_q   <= {s_r, out_q[WIDTH-1:SLICE_W]};
          a_sh    <= a_sh >> SLICE_W;
          b_sh    <= b_sh >> SLICE_W;
          carry_q <= s_c;
          zacc_q  <= zacc_q & s_z;
          cnt     <= cnt + 1'b1;
          // Flags land on the same edge as the top slice so they match OUT.
          if (last) begin
            c_out_q <= s_c;
            zero_q  <= zacc_q & s_z;
            neg_q   <= s_r[SLICE_W-1];
            ovf_q   <= s_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.c_out     = c_out_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mlu_seq.sv
// Self-checking bench for mlu_seq at WIDTH=16, SLICE_W=4 against a full-width
// arithmetic reference model.
module tb_mlu_seq;
  import mlu_seq_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mlu_seq_if #(.WIDTH(W)) bus ();

  mlu_seq #(.WIDTH(W), .SLICE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input mlu_op_t op, input logic cin);
    res_t         e;
    logic [W:0]   s;
    logic [W-1:0] bb;
    e  = '0;
    s  = '0;
    bb = (op == MLU_SUB) ? ~b : b;
    case (op)
      MLU_ADD, MLU_SUB: begin
        s     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        e.out = s[W-1:0];
        e.c   = s[W];
        e.v   = (a[W-1] == bb[W-1]) && (e.out[W-1] != a[W-1]);
      end
      MLU_AND: e.out = a & b;
      MLU_OR:  e.out = a | b;
      MLU_XOR: e.out = a ^ b;
      MLU_NOT: e.out = ~a;
      default: e.out = '0;
    endcase
    e.z = (e.out == '0);
    e.n = e.out[W-1];
    return e;
  endfunction

  function automatic res_t observe();
    return '{out: bus.out, c: bus.c_out, z: bus.zero, n: bus.neg, v: bus.ovf};
  endfunction

  // Issue one request and wait (bounded) until the result is presented.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input mlu_op_t op, input logic cin, output int lat);
    int w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout waited=%0d cycles", w);
    end
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.op = op; bus.c_in = cin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
      if (lat >= 50) begin
        checks++; failures++;
        $display("FAIL out_valid_timeout after %0d cycles", lat);
        break;
      end
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, observe()} !== {1'b1, 1'b0, res_t'('0)}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0",
               bus.in_ready, bus.out_valid, observe());
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'hA5A5, 16'h0F0F, 16'h1234};
    logic [W-1:0] tb [6] = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h5555, 16'h4321};
    mlu_op_t      to [6] = '{MLU_ADD, MLU_SUB, MLU_ADD, MLU_XOR, MLU_NOT, MLU_NOP1};
    logic         tc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    res_t         te [6] = '{'{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0},
                             '{16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1},
                             '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1},
                             '{16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0},
                             '{16'hF0F0, 1'b0, 1'b0, 1'b1, 1'b0},
                             '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}};
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], to[i], tc[i], lat);
      checks++;
      if (lat !== LAT) begin
        failures++;
        $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if (observe() !== te[i]) begin
        failures++;
        $display("FAIL directed_result[%0d] got %h want %h", i, observe(), te[i]);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    res_t snap, exp;
    int   lat;
    exp = model(16'h1234, 16'h1111, MLU_ADD, 1'b0);
    do_op(16'h1234, 16'h1111, MLU_ADD, 1'b0, lat);
    snap = observe();
    checks++;
    if (snap !== exp) begin
      failures++;
      $display("FAIL bp_result got %h want %h", snap, exp);
    end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.a = 16'($urandom); bus.b = 16'($urandom);
      bus.op = MLU_XOR;
      @(posedge clk); #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, observe()} !== {1'b0, 1'b1, exp}) begin
        failures++;
        $display("FAIL bp_hold[%0d] got rdy=%b vld=%b res=%h want rdy=0 vld=1 res=%h",
                 i, bus.in_ready, bus.out_valid, observe(), exp);
      end
    end
    bus.in_valid = 1'b0;
    release_out();
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL bp_no_queue got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_busy();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.op = MLU_ADD; bus.c_in = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL rst_busy got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0000",
               bus.in_ready, bus.out_valid, bus.out);
    end
    do_op(16'd3, 16'd4, MLU_ADD, 1'b0, lat);
    checks++;
    if ({lat[7:0], bus.out} !== {8'(LAT), 16'h0007}) begin
      failures++;
      $display("FAIL rst_then_add got lat=%0d out=%h want lat=%0d out=0007", lat, bus.out, LAT);
    end
    release_out();
  endtask

  task automatic test_multiword();
    int   lat;
    logic cy;
    do_op(16'hFFFF, 16'h0001, MLU_ADD, 1'b0, lat);
    cy = bus.c_out;
    checks++;
    if ({bus.c_out, bus.out} !== {1'b1, 16'h0000}) begin
      failures++;
      $display("FAIL mw_low got c=%b out=%h want c=1 out=0000", bus.c_out, bus.out);
    end
    release_out();
    do_op(16'h0000, 16'h0000, MLU_ADD, cy, lat);
    checks++;
    if ({bus.c_out, bus.zero, bus.out} !== {1'b0, 1'b0, 16'h0001}) begin
      failures++;
      $display("FAIL mw_high got c=%b z=%b out=%h want c=0 z=0 out=0001",
               bus.c_out, bus.zero, bus.out);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    mlu_op_t      op;
    logic         cin;
    res_t         exp;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      op  = mlu_op_t'($urandom_range(0, 7));
      cin = 1'($urandom);
      if (i % 8 == 0) b = ~a;
      exp = model(a, b, op, cin);
      do_op(a, b, op, cin, lat);
      checks++;
      if (lat !== LAT) begin
        failures++;
        $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, LAT);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if (observe() !== exp) begin
        failures++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h cin=%b got %h want %h",
                 i, op, a, b, cin, observe(), exp);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    int errs = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 16'd1; bus.b = 16'd2; bus.op = MLU_ADD; bus.c_in = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        hits.push_back(c);
        if (bus.out !== 16'h0003) errs++;
      end
    end
    bus.in_valid = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int k = 1; k < hits.size(); k++)
      if (hits[k] - hits[k-1] != LAT + 2) errs++;
    checks++;
    if (hits.size() < 6 || errs != 0) begin
      failures++;
      $display("FAIL back_to_back got results=%0d bad=%0d want results>=6 bad=0 (interval %0d)",
               hits.size(), errs, LAT + 2);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = MLU_NOP0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_busy();
    test_multiword();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mlu_seq.md
# mlu_seq

Multi-cycle, width-parametrised MLU that evaluates a WIDTH-bit operation one SLICE_W-bit slice per clock, least-significant slice first, with a registered ripple carry between slices. It replaces a chain of combinational slices where area matters more than latency. It sits between the register file read stage and writeback, behind valid/ready handshakes on both sides. It adds full-width flags (carry, zero, negative, signed overflow) and external carry-in for multi-word arithmetic.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE_W and at least 2*SLICE_W.
- SLICE_W, 4, bits processed per cycle; N = WIDTH/SLICE_W cycles per operation.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  block can accept a request; high only in IDLE.
- A, B  in  WIDTH  operands, captured on accept.
- OP  in  3  common::MLU_* opcode (ADD, SUB, AND, OR, XOR, NOT, NOP0, NOP1), captured on accept.
- C_IN  in  1  carry into slice 0 for ADD/SUB, captured on accept; caller drives 1 for plain SUB.
- OUT_VALID  out  1  result and flags valid.
- OUT_READY  in  1  consumer accepts result.
- OUT  out  WIDTH  result.
- C_OUT  out  1  carry out of top slice (ADD/SUB), else 0.
- ZERO  out  1  OUT == 0.
- NEG  out  1  OUT[WIDTH-1].
- OVF  out  1  signed overflow (ADD/SUB), else 0.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: IN_READY=1. IN_VALID high → capture A, B (shift registers), OP, carry←C_IN, slice counter←0, zero accumulator←1, go BUSY.
- BUSY: each cycle compute slice k from low SLICE_W bits of A/B regs and carry reg. Shift result into OUT from top. Shift A/B right by SLICE_W. Update carry reg and zero accumulator. Increment counter. After slice N-1, go DONE.
- Per-slice function: ADD a+b+c. SUB a+~b+c. AND, OR, XOR bitwise. NOT ~a. NOP0/NOP1 zero. For logical ops and NOPs, carry reg forced 0 every slice.
- OVF: for ADD, (a_msb == b_msb) && (r_msb != a_msb). SUB uses ~b_msb in place of b_msb. msb values taken in the last slice.
- DONE: OUT_VALID=1. Outputs held stable while OUT_READY low. OUT_READY high → go IDLE.
- IN_VALID is ignored outside IDLE; no request is queued.
- Reset in any state: abandon the operation and go IDLE.

## Timing
- Reset values: state IDLE, IN_READY=1, OUT_VALID=0, OUT=0, C_OUT=0, ZERO=0, NEG=0, OVF=0.
- Accept on edge t. Slice k is registered on edge t+1+k. OUT_VALID rises after edge t+N.
- Latency is N cycles from accept to OUT_VALID. Minimum initiation interval is N+2 cycles: DONE, then IDLE.
- Handshake: transfer occurs when VALID && READY are high at the rising edge.
- OUT_VALID drops on the edge after the OUT_READY transfer. IN_READY rises on the same edge.
- Flags are registered with the last slice and stay coherent with OUT.

## Structure
- common package additions:
  - mlu_seq_state_t enum (IDLE, BUSY, DONE).
  - Reuse the existing MLU_* opcode enum unchanged.
- Sub-module mlu_slice_fn: combinational, parameter SLICE_W. Inputs a, b, op, c_in. Outputs r, c_out, zero.
- The top level holds the FSM, shift registers, counter ($clog2(N) bits), carry/zero/flag registers.

## Test plan
- WIDTH=16. ADD 0xFFFF+0x0001, C_IN=0 → OUT=0x0000, C_OUT=1, ZERO=1, NEG=0, OVF=0. OUT_VALID exactly 4 cycles after accept.
- SUB 0x8000-0x0001, C_IN=1 → OUT=0x7FFF, C_OUT=1, OVF=1, NEG=0. ADD 0x7FFF+0x0001 → 0x8000, OVF=1, NEG=1.
- XOR 0xA5A5,0xFFFF → 0x5A5A, C_OUT=0. NOT 0x0F0F → 0xF0F0. NOP1 → 0x0000, ZERO=1. In all three, C_IN=1 has no effect.
- Backpressure: OUT_READY low 3 cycles in DONE → OUT and flags unchanged, IN_READY=0, IN_VALID pulses ignored. OUT_READY high → IDLE next cycle.
- RST asserted during BUSY at slice 2 → next cycle IDLE, OUT_VALID=0, OUT=0, IN_READY=1. A fresh ADD 3+4 then yields 0x0007.
- Multi-word: low word ADD 0xFFFF+0x0001 gives C_OUT=1. High word ADD 0x0000+0x0000 with C_IN=1 → 0x0001.
